// File: rtl/axis_mem_ctrl_burst.sv
// Burst scratch memory behind an AXI-Stream command/write slave and read master.
// Optional write acknowledge beat enabled by defining AXIS_MEM_CTRL_WR_ACK_EN.
module axis_mem_ctrl_burst #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    busy
);

   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_RD_FETCH,
      S_RD_SEND,
      S_DRAIN
`ifdef AXIS_MEM_CTRL_WR_ACK_EN
      , S_WR_ACK
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [LEN_WIDTH:0]      wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

   logic                    s_rdy;
   logic                    s_fire;
   logic                    wr_en;
   logic                    m_valid;
   logic                    m_last;
   logic [DATA_WIDTH-1:0]   m_data;
   state_t                  wr_done;

   logic [ADDR_WIDTH-1:0]   hdr_addr;
   logic [LEN_WIDTH-1:0]    hdr_len;
   logic                    hdr_op;
   logic                    unused_tdata;

   assign hdr_addr     = s_axis_tdata[ADDR_WIDTH-1:0];
   assign hdr_len      = s_axis_tdata[ADDR_WIDTH +: LEN_WIDTH];
   assign hdr_op       = s_axis_tdata[DATA_WIDTH-1];
   assign unused_tdata = ^s_axis_tdata;

   assign s_rdy = (state_q == S_IDLE) || (state_q == S_WR_DATA) ||
                  (state_q == S_DRAIN);
   assign s_axis_tready = s_rdy & ~axis_areset;
   assign s_fire        = s_axis_tvalid & s_axis_tready;

   assign m_axis_tvalid = m_valid;
   assign m_axis_tlast  = m_last;
   assign m_axis_tdata  = m_data;
   assign m_axis_tstrb  = {NB{m_valid}};
   assign busy          = (state_q != S_IDLE);

`ifdef AXIS_MEM_CTRL_WR_ACK_EN
   assign wr_done = S_WR_ACK;
`else
   assign wr_done = S_IDLE;
`endif

   // Next-state, pointer/counter updates and master outputs.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      wr_en   = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (s_fire) begin
               ptr_d  = hdr_addr;
               cnt_d  = hdr_len;
               wcnt_d = '0;
               if (hdr_op)
                  state_d = s_axis_tlast ? wr_done : S_WR_DATA;
               else
                  state_d = s_axis_tlast ? S_RD_FETCH : S_DRAIN;
            end
         end
         S_WR_DATA: begin
            if (s_fire) begin
               // wcnt never passes len, so it doubles as the ack count.
               if (wcnt_q <= {1'b0, cnt_q}) begin
                  wr_en  = 1'b1;
                  wcnt_d = wcnt_q + 1'b1;
               end
               ptr_d = ptr_q + 1'b1;
               if (s_axis_tlast)
                  state_d = wr_done;
            end
         end
         S_RD_FETCH: begin
            state_d = S_RD_SEND;
         end
         S_RD_SEND: begin
            m_valid = 1'b1;
            m_last  = (cnt_q == '0);
            m_data  = rdata_q;
            if (m_axis_tready) begin
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  cnt_d   = cnt_q - 1'b1;
                  state_d = S_RD_FETCH;
               end
            end
         end
         S_DRAIN: begin
            if (s_fire && s_axis_tlast)
               state_d = S_IDLE;
         end
`ifdef AXIS_MEM_CTRL_WR_ACK_EN
         S_WR_ACK: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = DATA_WIDTH'(wcnt_q);
            if (m_axis_tready)
               state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Byte-masked write port and registered read port; contents survive reset.
   always_ff @(posedge axis_aclk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (s_axis_tstrb[i])
               mem[ptr_q][i*8 +: 8] <= s_axis_tdata[i*8 +: 8];
         end
      end
      if (state_q == S_RD_FETCH)
         rdata_q <= mem[ptr_q];
   end

endmodule

// File: doc/axis_mem_ctrl_burst.md
Name: axis_mem_ctrl_burst

Overview:
Single-clock, parametrised on-chip memory controller with an AXI-Stream command/write slave and an AXI-Stream read master. Packets on the slave start with a header beat that selects write or read, a start word address and a burst length. Writes honour per-byte strobes. Reads return a burst with tlast on the final beat. Used as the shared scratch memory between stream processing blocks.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words.
LEN_WIDTH, 8, burst length field width; a burst is 1..2**LEN_WIDTH beats. ADDR_WIDTH+LEN_WIDTH must be at most DATA_WIDTH-1.

Ports:
axis_aclk  in  1  clock, shared by both interfaces
axis_areset  in  1  synchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  header or write data
s_axis_tstrb  in  DATA_WIDTH/8  byte enables for write data beats
s_axis_tvalid  in  1  slave valid
s_axis_tlast  in  1  end of slave packet
s_axis_tready  out  1  slave ready
m_axis_tdata  out  DATA_WIDTH  read data
m_axis_tstrb  out  DATA_WIDTH/8  always all-ones when valid
m_axis_tvalid  out  1  master valid
m_axis_tlast  out  1  last beat of read burst
m_axis_tready  in  1  master ready
busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Interface decision: one clock (axis_aclk); reset (axis_areset) is synchronous and active-high.
- Reset: FSM to IDLE; s_axis_tready=0 while reset is high. m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata and m_axis_tstrb are all 0. Memory contents are not cleared. Reset mid-burst aborts immediately and emits no partial tlast.
- Handshake: a beat transfers on the cycle valid&ready are both high. m_axis_tdata, m_axis_tstrb and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Header fields (first beat of each packet):
  - addr = tdata[ADDR_WIDTH-1:0]
  - len-1 = tdata[ADDR_WIDTH+LEN_WIDTH-1:ADDR_WIDTH]
  - op = tdata[DATA_WIDTH-1] (1=write, 0=read)
  - tstrb is ignored on the header.
- s_axis_tready: 1 in IDLE, WR_DATA and DRAIN; 0 in RD_FETCH, RD_SEND and WR_ACK.
- States:
  - IDLE:
    - On header accept, load ptr=addr and cnt=len-1.
    - Write op with tlast=0 -> WR_DATA.
    - Write op with tlast=1 -> IDLE (no-op, no data).
    - Read op with tlast=1 -> RD_FETCH.
    - Read op with tlast=0 -> DRAIN (malformed; no read is performed).
  - WR_DATA:
    - Each accepted beat writes byte i of mem[ptr] only where tstrb[i]=1.
    - ptr increments modulo 2**ADDR_WIDTH (wraps from max to 0).
    - Beats beyond len are accepted but not written.
    - tlast -> IDLE, or WR_ACK if the optional feature is enabled. A packet shorter than len ends cleanly at tlast.
  - RD_FETCH: one cycle; synchronous memory read of mem[ptr] -> RD_SEND.
  - RD_SEND:
    - m_axis_tvalid=1, tdata=read word, tstrb=all-ones, tlast=(cnt==0).
    - On handshake: if cnt==0 -> IDLE; else ptr++ (wrapping), cnt-- -> RD_FETCH.
  - DRAIN: accept and discard beats until tlast is accepted -> IDLE.
- Latency and throughput: first read beat is valid 2 cycles after the read header is accepted. Read throughput is 1 beat per 2 cycles with tready held high. Write throughput is 1 beat per cycle.
- Write-after-read: data written by one packet is visible to any read header accepted after that packet's tlast.

Optional Feature:
Macro AXIS_MEM_CTRL_WR_ACK_EN.
- Defined: after a write packet's tlast (including the no-data write header), the FSM enters WR_ACK. It presents one beat with m_axis_tvalid=1, tlast=1, tstrb=all-ones and tdata = number of beats actually written (zero-extended, saturating at len). It returns to IDLE on handshake.
- Undefined: there is no WR_ACK state; writes produce no master traffic.

Test Plan:
- Reset, then write header addr=0x010 len=4 + beats 0xA0..0xA3 with tstrb=0xF; then read header addr=0x010 len=4 -> master emits 0xA0,0xA1,0xA2,0xA3, tlast only on the 4th beat, first tvalid 2 cycles after header.
- Write 0xFFFFFFFF to addr 0x020, then write 0x12345678 with tstrb=0x5; read addr 0x020 len=1 -> 0xFF34FF78, tlast=1.
- Write 2 beats at addr 0x3FF (ADDR_WIDTH=10) -> read addr 0x3FF len=2 returns beat0 then the word at 0x000 (wrap).
- Read len=3 with m_axis_tready toggling 1-0-0-1 -> tdata/tlast held stable while stalled; exactly 3 beats transferred; s_axis_tready=0 throughout.
- Read header with tlast=0 followed by 2 junk beats (last with tlast) -> no master traffic, s_axis_tready stays 1, busy drops after tlast.
- Assert axis_areset during the 2nd beat of a 4-beat read -> next cycle m_axis_tvalid=0, busy=0; a subsequent read of the same address returns the previously written data.
